sd_sector_reader: RTL and testbench



---
 rtl/sd_sector_reader_if.sv | 32 +++
 rtl/sd_sector_reader.sv | 208 ++++++++++++++++++++
 tb/tb_sd_sector_reader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_reader_if.sv
// Avalon-MM master bus toward the Altera UP SD card slave, plus the byte stream
// toward the consumer. Both sides of the block are bundled here.
interface sd_sector_reader_if;
  logic [7:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  // Stream: a byte moves on every cycle with out_valid & out_ready; once out_valid
  // rises it stays high with out_data frozen until that cycle, and valid never
  // depends combinationally on ready.
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sd_sector_reader.sv
// Reads one 512-byte sector from the Altera UP SD card IP over Avalon-MM and
// streams it out byte by byte, little-endian within each 32-bit buffer word.
module sd_sector_reader #(
  parameter logic [7:0]  ASR_ADDR       = 8'h8D,
  parameter logic [7:0]  CMD_ARG_ADDR   = 8'h8B,
  parameter logic [7:0]  CMD_ADDR       = 8'h8C,
  parameter logic [31:0] READ_BLOCK_CMD = 32'd17,
  parameter logic [23:0] POLL_TIMEOUT   = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] sector,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [2:0]  dbg_state,
  sd_sector_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CARD = 3'd1,
    WR_ARG    = 3'd2,
    WR_CMD    = 3'd3,
    POLL_BUSY = 3'd4,
    RD_WORD   = 3'd5,
    EMIT      = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t      state, state_next;
  logic [22:0] sector_q;
  logic [31:0] hold_q;
  logic [31:0] writedata_q;
  logic [7:0]  address_q;
  logic        read_q, write_q;
  logic [23:0] timer_q;
  logic [6:0]  index_q;
  logic [1:0]  byte_q;
  logic        error_q;
  logic [1:0]  code_q;

  logic        rd_done, wr_done, timed_out, handshake;
  logic        fin_err;
  logic [1:0]  fin_code;
  logic        req_read, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        unused;

  assign unused    = ^sector[31:23];
  assign rd_done   = read_q & ~bus.avm_waitrequest;
  assign wr_done   = write_q & ~bus.avm_waitrequest;
  assign timed_out = (timer_q == POLL_TIMEOUT);
  assign handshake = (state == EMIT) & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fin_err    = 1'b0;
    fin_code   = 2'b00;
    case (state)
      IDLE:      if (start) state_next = WAIT_CARD;
      WAIT_CARD: begin
        if (rd_done && bus.avm_readdata[1]) state_next = WR_ARG;
        else if (timed_out) begin
          state_next = FINISH;
          fin_err    = 1'b1;
          fin_code   = 2'b01;
        end
      end
      WR_ARG:    if (wr_done) state_next = WR_CMD;
      WR_CMD:    if (wr_done) state_next = POLL_BUSY;
      POLL_BUSY: begin
        if (rd_done && !bus.avm_readdata[2]) begin
          if (bus.avm_readdata[4] || bus.avm_readdata[5]) begin
            state_next = FINISH;
            fin_err    = 1'b1;
            fin_code   = 2'b11;
          end else begin
            state_next = RD_WORD;
          end
        end else if (timed_out) begin
          state_next = FINISH;
          fin_err    = 1'b1;
          fin_code   = 2'b10;
        end
      end
      RD_WORD:   if (rd_done) state_next = EMIT;
      EMIT:      if (handshake && byte_q == 2'd3)
                   state_next = (index_q == 7'd127) ? FINISH : RD_WORD;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Transfer each state wants to issue; only launched while no strobe is up.
  always_comb begin
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = ASR_ADDR;
    req_data  = 32'd0;
    case (state)
      WAIT_CARD, POLL_BUSY: req_read = 1'b1;
      WR_ARG: begin
        req_write = 1'b1;
        req_addr  = CMD_ARG_ADDR;
        req_data  = {sector_q, 9'd0};
      end
      WR_CMD: begin
        req_write = 1'b1;
        req_addr  = CMD_ADDR;
        req_data  = READ_BLOCK_CMD;
      end
      RD_WORD: begin
        req_read = 1'b1;
        req_addr = {1'b0, index_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= 8'd0;
      writedata_q <= 32'd0;
    end else if (rd_done || wr_done || state_next != state) begin
      // Drop on completion (forces an idle gap) or when a timeout abandons the state.
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (!read_q && !write_q && (req_read || req_write)) begin
      read_q      <= req_read;
      write_q     <= req_write;
      address_q   <= req_addr;
      writedata_q <= req_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sector_q <= 23'd0;
      hold_q   <= 32'd0;
      timer_q  <= 24'd0;
      index_q  <= 7'd0;
      byte_q   <= 2'd0;
      error_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      if (state == IDLE && start) begin
        sector_q <= sector[22:0];
        error_q  <= 1'b0;
        code_q   <= 2'b00;
      end
      if ((state == IDLE && start) || (state == WR_CMD && wr_done))
        timer_q <= 24'd0;
      else if ((state == WAIT_CARD || state == POLL_BUSY) && !timed_out)
        timer_q <= timer_q + 24'd1;
      if (state == POLL_BUSY && state_next == RD_WORD)
        index_q <= 7'd0;
      if (state == RD_WORD && rd_done) begin
        hold_q <= bus.avm_readdata;
        byte_q <= 2'd0;
      end
      if (handshake) begin
        byte_q <= byte_q + 2'd1;
        if (byte_q == 2'd3 && index_q != 7'd127)
          index_q <= index_q + 7'd1;
      end
      if (state_next == FINISH && state != FINISH) begin
        error_q <= fin_err;
        code_q  <= fin_code;
      end
    end
  end

  always_comb begin
    bus.out_data = hold_q[7:0];
    case (byte_q)
      2'd1:    bus.out_data = hold_q[15:8];
      2'd2:    bus.out_data = hold_q[23:16];
      2'd3:    bus.out_data = hold_q[31:24];
      default: bus.out_data = hold_q[7:0];
    endcase
  end

  assign bus.out_valid      = (state == EMIT);
  assign bus.avm_address    = address_q;
  assign bus.avm_writedata  = writedata_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_chipselect = read_q | write_q;
  assign bus.avm_byteenable = 4'b1111;

  assign busy       = (state != IDLE) && (state != FINISH);
  assign done       = (state == FINISH);
  assign error      = error_q;
  assign error_code = code_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: behavioural SD IP slave, byte stream consumer and
// scenario tasks covering success, every error code, stalls and mid-run reset.
module tb_sd_sector_reader;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] sector;
  logic        busy, done, error;
  logic [1:0]  error_code;
  logic [2:0]  dbg_state;

  sd_sector_reader_if bus ();

  sd_sector_reader #(.POLL_TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .start(start), .sector(sector), .busy(busy), .done(done),
    .error(error), .error_code(error_code), .dbg_state(dbg_state), .bus(bus.master)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  // ---------------- slave model ----------------
  int   stall_left = 0, max_stall = 0, busy_left = 0, busy_init = 0;
  logic card = 1'b1, busy_stuck = 1'b0, flag4 = 1'b0;
  logic [31:0] asr_word;

  assign asr_word = {26'd0, 1'b0, flag4, 1'b0, (busy_stuck || busy_left != 0), card, 1'b0};
  assign bus.avm_readdata = (bus.avm_address == 8'h8D) ? asr_word :
                            (bus.avm_address < 8'd128) ? {4{bus.avm_address}} : 32'hDEADBEEF;
  assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (stall_left != 0);

  always @(posedge clk) begin
    if (bus.avm_read || bus.avm_write) begin
      if (stall_left != 0) stall_left <= stall_left - 1;
      else begin
        stall_left <= $urandom_range(0, max_stall);
        if (bus.avm_read && bus.avm_address == 8'h8D && busy_left != 0) busy_left <= busy_left - 1;
        if (bus.avm_write && bus.avm_address == 8'h8C) busy_left <= busy_init;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0, valid_cnt = 0, proto_err = 0;
  logic        last_err, busy_at_done;
  logic [1:0]  last_code;
  logic        av_prev = 1'b0, out_prev = 1'b0, sv_rd, sv_wr;
  logic [7:0]  sv_addr, sv_out;
  logic [31:0] sv_data;

  always @(negedge clk) begin
    if (reset) begin
      av_prev  = 1'b0;
      out_prev = 1'b0;
    end else begin
      if (av_prev && (bus.avm_address !== sv_addr || bus.avm_writedata !== sv_data ||
                      bus.avm_read !== sv_rd || bus.avm_write !== sv_wr)) proto_err++;
      if (bus.avm_chipselect !== (bus.avm_read | bus.avm_write) || bus.avm_byteenable !== 4'hF)
        proto_err++;
      av_prev = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      sv_addr = bus.avm_address; sv_data = bus.avm_writedata;
      sv_rd   = bus.avm_read;    sv_wr   = bus.avm_write;
      if (out_prev && (bus.out_valid !== 1'b1 || bus.out_data !== sv_out)) proto_err++;
      out_prev = bus.out_valid && !bus.out_ready;
      sv_out   = bus.out_data;
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wr_addr_q.push_back(bus.avm_address);
        wr_data_q.push_back(bus.avm_writedata);
      end
      if (done) begin
        done_cnt++;
        last_err = error; last_code = error_code; busy_at_done = busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sector_bytes();
    for (int n = 0; n < 512; n++) exp_q.push_back(8'(n >> 2));
  endtask

  task automatic clear_logs();
    exp_q.delete(); rx_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    valid_cnt = 0; proto_err = 0;
  endtask

  // Pulses start, then waits (bounded) for done while driving out_ready.
  task automatic run_op(input logic [31:0] sec, input bit rand_ready, input int restart_at,
                        output int cycles, output int dones);
    int base, run_left;
    base = done_cnt; run_left = 0;
    @(posedge clk); #1;
    sector = sec; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sector = 32'hFFFF_FFFF;
    vectors++;
    if (busy !== 1'b1 || error_code !== 2'b00) begin
      miscompares++;
      $display("FAIL start_accept: busy=%b code=%b, want busy=1 code=00", busy, error_code);
    end
    cycles = 0;
    while (done_cnt == base && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == restart_at) begin start = 1'b1; sector = 32'd99; end
      else start = 1'b0;
      if (rand_ready) begin
        if (run_left == 0) begin
          if ($urandom_range(0, 9) < 2) begin
            bus.out_ready = 1'b0; run_left = $urandom_range(20, 60);
          end else begin
            bus.out_ready = 1'($urandom_range(0, 1)); run_left = $urandom_range(1, 4);
          end
        end else run_left--;
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cnt == base) begin
      miscompares++;
      $display("FAIL done_timeout: no done after %0d cycles, want done", cycles);
    end
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    dones = done_cnt - base;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, error, error_code, bus.out_valid} !== 6'd0 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/err/code/valid=%b state=%0d, want all 0",
               {busy, done, error, error_code, bus.out_valid}, dbg_state);
    end
    vectors++;
    if ({bus.avm_read, bus.avm_write, bus.avm_chipselect} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: %b, want 000", {bus.avm_read, bus.avm_write, bus.avm_chipselect});
    end
    vectors++;
    if (bus.avm_address !== 8'd0 || bus.avm_writedata !== 32'd0 || bus.out_data !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h out=%h, want 0", bus.avm_address,
               bus.avm_writedata, bus.out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read_sector(input string name, input logic [31:0] sec, input bit rand_ready,
                                  input int restart_at);
    int cycles, dones, shown;
    logic [7:0] e, r;
    clear_logs();
    push_sector_bytes();
    run_op(sec, rand_ready, restart_at, cycles, dones);
    vectors++;
    if (dones !== 1 || last_err !== 1'b0 || last_code !== 2'b00 || busy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: pulses=%0d err=%b code=%b busy=%b, want 1/0/00/0", name, dones,
               last_err, last_code, busy_at_done);
    end
    vectors++;
    if (wr_addr_q.size() !== 2) begin
      miscompares++;
      $display("FAIL %s_write_count: %0d, want 2", name, wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 8'h8B || wr_data_q[0] !== {sec[22:0], 9'd0}) begin
        miscompares++;
        $display("FAIL %s_arg_write: %h<=%h, want 8b<=%h", name, wr_addr_q[0], wr_data_q[0],
                 {sec[22:0], 9'd0});
      end
      vectors++;
      if (wr_addr_q[1] !== 8'h8C || wr_data_q[1] !== 32'd17) begin
        miscompares++;
        $display("FAIL %s_cmd_write: %h<=%h, want 8c<=11", name, wr_addr_q[1], wr_data_q[1]);
      end
    end
    vectors++;
    if (rx_q.size() !== 512) begin
      miscompares++;
      $display("FAIL %s_byte_count: %0d, want 512", name, rx_q.size());
    end
    shown = 0;
    for (int n = 0; n < 512 && rx_q.size() != 0; n++) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      vectors++;
      if (r !== e) begin
        miscompares++;
        if (shown < 4) $display("FAIL %s_byte[%0d]: %h, want %h", name, n, r, e);
        shown++;
      end
    end
    vectors++;
    if (proto_err !== 0) begin
      miscompares++;
      $display("FAIL %s_protocol: %0d stability/strobe violations, want 0", name, proto_err);
    end
  endtask

  task automatic test_error(input string name, input logic [1:0] code, input int cycle_limit,
                            input int want_writes);
    int cycles, dones;
    clear_logs();
    run_op(32'd5, 1'b0, 0, cycles, dones);
    vectors++;
    if (dones !== 1 || last_err !== 1'b1 || last_code !== code) begin
      miscompares++;
      $display("FAIL %s_done: pulses=%0d err=%b code=%b, want 1/1/%b", name, dones, last_err,
               last_code, code);
    end
    vectors++;
    if (cycles > cycle_limit) begin
      miscompares++;
      $display("FAIL %s_latency: %0d cycles, want <= %0d", name, cycles, cycle_limit);
    end
    vectors++;
    if (valid_cnt !== 0 || rx_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_no_bytes: valid cycles=%0d bytes=%0d, want 0", name, valid_cnt, rx_q.size());
    end
    vectors++;
    if (wr_addr_q.size() !== want_writes) begin
      miscompares++;
      $display("FAIL %s_writes: %0d, want %0d", name, wr_addr_q.size(), want_writes);
    end
    vectors++;
    if (error_code !== code || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_code_hold: code=%b busy=%b, want %b/0", name, error_code, busy, code);
    end
  endtask

  task automatic test_reset_mid_emit();
    int cycles;
    clear_logs();
    @(posedge clk); #1;
    sector = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (rx_q.size() < 162 && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
    end
    vectors++;
    if (rx_q.size() < 162) begin
      miscompares++;
      $display("FAIL midreset_reach: %0d bytes, want 162", rx_q.size());
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.avm_read, bus.avm_write, bus.avm_chipselect, bus.out_valid, busy} !== 5'd0 ||
        dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL midreset_drop: rd/wr/cs/valid/busy=%b state=%0d, want 0",
               {bus.avm_read, bus.avm_write, bus.avm_chipselect, bus.out_valid, busy}, dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    test_read_sector("after_reset", 32'd1, 1'b0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; start = 1'b0; sector = 32'd0; bus.out_ready = 1'b1;
    test_reset();
    test_read_sector("basic", 32'd5, 1'b0, 0);
    card = 1'b0;
    test_error("no_card", 2'b01, 110, 0);
    card = 1'b1;
    busy_stuck = 1'b1;
    test_error("cmd_timeout", 2'b10, 300, 2);
    busy_stuck = 1'b0;
    busy_init = 3; flag4 = 1'b1;
    test_error("crc_flag", 2'b11, 300, 2);
    busy_init = 0; flag4 = 1'b0;
    max_stall = 5;
    test_read_sector("stalls", 32'd5, 1'b0, 0);
    test_read_sector("ready_random", 32'h0040_0007, 1'b1, 50);
    max_stall = 2;
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
